// File: rtl/mem_access_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory access sequencer.
//   state_e          - 3-bit FSM state encoding (IDLE=0 ... ERR=7)
//   OP_LOAD/OP_STORE - encoding of the latched request type
//   WAIT_MAX_DEFAULT - default wait-cycle budget before timeout
//   ctrl_out_t       - bundle of all sequencer outputs
//   decode_outputs() - per-state output table

package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAddr    = 3'd1,
        StRdWait  = 3'd2,
        StRdLatch = 3'd3,
        StWrLoad  = 3'd4,
        StWrWait  = 3'd5,
        StDone    = 3'd6,
        StErr     = 3'd7
    } state_e;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    localparam int unsigned WAIT_MAX_DEFAULT = 15;

    typedef struct packed {
        logic mar_enable;
        logic mdr_enable;
        logic mdr_read;
        logic mem_read;
        logic mem_write;
        logic bus_data_req;
        logic bus_hold;
        logic busy;
        logic done;
        logic error;
    } ctrl_out_t;

    // Output table. mem_read only ever appears together with mdr_read, and
    // mem_write only with mdr_read=0, so there is never more than one driver
    // on the memory lines.
    function automatic ctrl_out_t decode_outputs(state_e st, logic op);
        ctrl_out_t o;
        o = '0;
        unique case (st)
            StIdle: ;
            StAddr: begin
                o.busy       = 1'b1;
                o.mar_enable = 1'b1;
            end
            StRdWait: begin
                o.busy     = 1'b1;
                o.mem_read = 1'b1;
                o.mdr_read = 1'b1;
                o.bus_hold = 1'b1;
            end
            StRdLatch: begin
                o.busy       = 1'b1;
                o.mem_read   = 1'b1;
                o.mdr_read   = 1'b1;
                o.mdr_enable = 1'b1;
                o.bus_hold   = 1'b1;
            end
            StWrLoad: begin
                o.busy         = 1'b1;
                o.mdr_enable   = 1'b1;
                o.bus_data_req = 1'b1;
            end
            StWrWait: begin
                o.busy      = 1'b1;
                o.mem_write = 1'b1;
            end
            StDone: begin
                o.busy = 1'b1;
                o.done = 1'b1;
                // A finished load keeps the word on the bus for capture.
                if (op == OP_LOAD) begin
                    o.mdr_read = 1'b1;
                    o.bus_hold = 1'b1;
                end
            end
            StErr: begin
                o.busy  = 1'b1;
                o.done  = 1'b1;
                o.error = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// wait_timer: saturating wait-cycle counter for the memory sequencer.
//   clk_i     - clock
//   rst_ni    - synchronous active-low reset
//   clr_i     - clear the count to zero (takes priority over inc_i)
//   inc_i     - count one not-ready wait cycle
//   expired_o - this increment brings the count to WAIT_MAX

module wait_timer #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = $clog2(WAIT_MAX + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(WAIT_MAX);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MaxCnt)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Flag the WAIT_MAX-th not-ready cycle itself, so the FSM leaves the wait
    // state on that edge; a ready in the same cycle is handled first by the FSM.
    assign expired_o = inc_i && (count_q >= LastCnt);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one load or store per request through the
// MAR/MDR/RAM group, with a ready handshake and a wait timeout.
//   clock        - system clock (rising edge)
//   clear        - synchronous active-low reset
//   start        - request strobe, sampled in IDLE only
//   write_req    - request type captured with start (1 = store)
//   mem_ready    - RAM completion, sampled in the wait states only
//   mar_enable   - load MAR from bus
//   mdr_enable   - load MDR
//   mdr_read     - MDR direction (1 = from mem lines / drive bus)
//   mem_read     - RAM read strobe
//   mem_write    - RAM write strobe
//   bus_data_req - control unit must drive store data this cycle
//   bus_hold     - MDR may be driving the bus
//   busy         - not IDLE
//   done         - one-cycle completion pulse
//   error        - one-cycle timeout pulse, together with done

module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT,
    parameter int unsigned CNT_W    = $clog2(WAIT_MAX + 1)
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic write_req,
    input  logic mem_ready,
    output logic mar_enable,
    output logic mdr_enable,
    output logic mdr_read,
    output logic mem_read,
    output logic mem_write,
    output logic bus_data_req,
    output logic bus_hold,
    output logic busy,
    output logic done,
    output logic error
);

    state_e    state_q, state_d;
    logic      op_q, op_d;
    ctrl_out_t out_q;

    logic tmr_clr;
    logic tmr_inc;
    logic tmr_expired;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_wait_timer (
        .clk_i     (clock),
        .rst_ni    (clear),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAddr;
                    op_d    = write_req;
                    tmr_clr = 1'b1;
                end
            end
            StAddr: begin
                state_d = (op_q == OP_STORE) ? StWrLoad : StRdWait;
            end
            StRdWait: begin
                if (mem_ready) begin
                    state_d = StRdLatch;
                end else begin
                    tmr_inc = 1'b1;
                    if (tmr_expired) begin
                        state_d = StErr;
                    end
                end
            end
            StRdLatch: begin
                state_d = StDone;
            end
            StWrLoad: begin
                state_d = StWrWait;
            end
            StWrWait: begin
                if (mem_ready) begin
                    state_d = StDone;
                end else begin
                    tmr_inc = 1'b1;
                    if (tmr_expired) begin
                        state_d = StErr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StErr: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are flopped from the next state so they line up exactly with
    // state_q and come straight from registers.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= StIdle;
            op_q    <= OP_LOAD;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            out_q   <= decode_outputs(state_d, op_d);
        end
    end

    assign mar_enable   = out_q.mar_enable;
    assign mdr_enable   = out_q.mdr_enable;
    assign mdr_read     = out_q.mdr_read;
    assign mem_read     = out_q.mem_read;
    assign mem_write    = out_q.mem_write;
    assign bus_data_req = out_q.bus_data_req;
    assign bus_hold     = out_q.bus_hold;
    assign busy         = out_q.busy;
    assign done         = out_q.done;
    assign error        = out_q.error;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a phase-level reference model, a per-cycle
// compare process, directed scenarios with literal expectations, and a
// randomized soak.
// Output vector order: {mar_en, mdr_en, mdr_rd, mem_rd, mem_wr, bus_req,
// bus_hold, busy, done, error}.

module tb_mem_access_ctrl;

    localparam int WMAX = 4;

    // Reference phases
    localparam int P_IDLE   = 0;
    localparam int P_ADDR   = 1;
    localparam int P_RWAIT  = 2;
    localparam int P_RLATCH = 3;
    localparam int P_WLOAD  = 4;
    localparam int P_WWAIT  = 5;
    localparam int P_DONE   = 6;
    localparam int P_ERR    = 7;

    localparam logic [9:0] V_IDLE   = 10'b0000000000;
    localparam logic [9:0] V_ADDR   = 10'b1000000100;
    localparam logic [9:0] V_RWAIT  = 10'b0011001100;
    localparam logic [9:0] V_RLATCH = 10'b0111001100;
    localparam logic [9:0] V_WLOAD  = 10'b0100010100;
    localparam logic [9:0] V_WWAIT  = 10'b0000100100;
    localparam logic [9:0] V_DONE_L = 10'b0010001110;
    localparam logic [9:0] V_DONE_S = 10'b0000000110;
    localparam logic [9:0] V_ERR    = 10'b0000000111;

    logic clock     = 1'b0;
    logic clear     = 1'b0;
    logic start     = 1'b0;
    logic write_req = 1'b0;
    logic mem_ready = 1'b0;
    logic mar_enable, mdr_enable, mdr_read, mem_read, mem_write;
    logic bus_data_req, bus_hold, busy, done, error;
    logic [9:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    int ph       = P_IDLE;
    int waits    = 0;
    bit m_store  = 1'b0;
    int n_accept = 0;

    logic [9:0] tr [1:12];

    always #5 clock = ~clock;

    mem_access_ctrl #(
        .WAIT_MAX (WMAX)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .write_req    (write_req),
        .mem_ready    (mem_ready),
        .mar_enable   (mar_enable),
        .mdr_enable   (mdr_enable),
        .mdr_read     (mdr_read),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .bus_data_req (bus_data_req),
        .bus_hold     (bus_hold),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    assign outs = {mar_enable, mdr_enable, mdr_read, mem_read, mem_write,
                   bus_data_req, bus_hold, busy, done, error};

    function automatic logic [9:0] exp_out(int p, bit st);
        case (p)
            P_ADDR:   return V_ADDR;
            P_RWAIT:  return V_RWAIT;
            P_RLATCH: return V_RLATCH;
            P_WLOAD:  return V_WLOAD;
            P_WWAIT:  return V_WWAIT;
            P_DONE:   return st ? V_DONE_S : V_DONE_L;
            P_ERR:    return V_ERR;
            default:  return V_IDLE;
        endcase
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: advances one phase per rising edge from sampled inputs.
    task automatic model_step();
        if (!clear) begin
            ph      = P_IDLE;
            waits   = 0;
            m_store = 1'b0;
        end else begin
            case (ph)
                P_IDLE: if (start) begin
                    ph      = P_ADDR;
                    m_store = write_req;
                    waits   = 0;
                    n_accept++;
                end
                P_ADDR:   ph = m_store ? P_WLOAD : P_RWAIT;
                P_RWAIT, P_WWAIT: begin
                    if (mem_ready) begin
                        ph = (ph == P_RWAIT) ? P_RLATCH : P_DONE;
                    end else begin
                        waits++;
                        if (waits >= WMAX) ph = P_ERR;
                    end
                end
                P_RLATCH: ph = P_DONE;
                P_WLOAD:  ph = P_WWAIT;
                default:  ph = P_IDLE;
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Per-cycle compare against the model plus bus-safety invariants.
    initial begin
        forever begin
            @(negedge clock);
            check("model", outs, exp_out(ph, m_store));
            check("rd_wr_excl", {9'd0, mem_read & mem_write}, 10'd0);
            check("rd_needs_mdr_rd", {9'd0, mem_read & ~mdr_read}, 10'd0);
        end
    end

    // Called at a falling edge while IDLE. Ready is high during cycle r only.
    task automatic run_access(input bit wr, input int r, input int n);
        start     = 1'b1;
        write_req = wr;
        mem_ready = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clock);
            start     = 1'b0;
            tr[c]     = outs;
            mem_ready = (c == r);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        int dones;
        int acc0;

        clear = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_outs", outs, V_IDLE);
        clear = 1'b1;

        // Load, ready on the first wait cycle
        run_access(1'b0, 2, 5);
        check("ld_c1", tr[1], V_ADDR);
        check("ld_c2", tr[2], V_RWAIT);
        check("ld_c3", tr[3], V_RLATCH);
        check("ld_c4", tr[4], V_DONE_L);
        check("ld_c5", tr[5], V_IDLE);

        // Store, ready in the 4th WR_WAIT cycle
        run_access(1'b1, 6, 8);
        check("st_c1", tr[1], V_ADDR);
        check("st_c2", tr[2], V_WLOAD);
        for (int c = 3; c <= 6; c++) check("st_wait", tr[c], V_WWAIT);
        check("st_c7", tr[7], V_DONE_S);
        check("st_c8", tr[8], V_IDLE);
        for (int c = 1; c <= 8; c++) check("st_no_rd", {9'd0, tr[c][6]}, 10'd0);

        // Timeout on a load
        run_access(1'b0, 0, 7);
        for (int c = 2; c <= 5; c++) check("to_wait", tr[c], V_RWAIT);
        check("to_err", tr[6], V_ERR);
        check("to_idle", tr[7], V_IDLE);

        // Ready on the same cycle the count reaches WAIT_MAX
        run_access(1'b0, 5, 8);
        check("bd_wait", tr[5], V_RWAIT);
        check("bd_latch", tr[6], V_RLATCH);
        check("bd_done", tr[7], V_DONE_L);
        check("bd_idle", tr[8], V_IDLE);

        // Reset during the 2nd WR_WAIT cycle
        start     = 1'b1;
        write_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        check("mr_in_wait", outs, V_WWAIT);
        clear = 1'b0;
        @(negedge clock);
        check("mr_idle", outs, V_IDLE);
        clear = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("mr_no_done", {9'd0, done}, 10'd0);
        end

        // start held high: one IDLE cycle between accesses, period 5
        acc0      = n_accept;
        dones     = 0;
        start     = 1'b1;
        mem_ready = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            write_req = 1'($urandom);
            @(negedge clock);
            if (done) dones++;
            if ((c % 5) == 0) check("held_idle", outs, V_IDLE);
        end
        start     = 1'b0;
        mem_ready = 1'b0;
        check("held_dones", 10'(dones), 10'd6);
        check("held_accepts", 10'(n_accept - acc0), 10'd6);

        // Randomized soak with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            clear     = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 3) == 0);
            write_req = 1'($urandom);
            mem_ready = ($urandom_range(0, 4) == 0);
        end
        clear = 1'b1;
        start = 1'b0;
        repeat (12) @(negedge clock);
        check("final_idle", outs, V_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the memory data path: it drives the MAR load, the MDR enable/read controls and the RAM read/write strobes for one load or store per request. It sits between the control unit and the MAR/MDR/RAM group. It handles variable-latency memory through a ready handshake, guarantees that only one driver is ever on the memory lines, and aborts with an error if memory never responds.

## Interface
Parameters:
- WAIT_MAX, default 15: maximum number of RD_WAIT/WR_WAIT cycles before timeout (legal range 1–255).
- CNT_W, default $clog2(WAIT_MAX+1): width of the wait counter. Derived; do not override.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset; synchronous, active-low. Sampled at the rising edge.
- start  in  1  request strobe. Sampled only in IDLE.
- write_req  in  1  sampled with start. 1 = store, 0 = load.
- mem_ready  in  1  RAM completion; sampled in RD_WAIT/WR_WAIT only.
- mar_enable  out  1  MAR load from bus.
- mdr_enable  out  1  MDR register load.
- mdr_read  out  1  MDR direction. 1 = load from mem lines / drive bus; 0 = load from bus / drive mem lines.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- bus_data_req  out  1  the control unit must place store data on the bus this cycle.
- bus_hold  out  1  MDR may be driving the bus; no other bus driver is allowed.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse, coincident with done, on timeout.

## Operation
- States: IDLE, ADDR, RD_WAIT, RD_LATCH, WR_LOAD, WR_WAIT, DONE, ERR.
- IDLE: all outputs 0. start=1 → ADDR; write_req is latched into an internal op register.
- ADDR: mar_enable=1. Next state is WR_LOAD if op=store, otherwise RD_WAIT.
- RD_WAIT: mem_read=1, mdr_read=1, bus_hold=1.
  - mem_ready=1 → RD_LATCH.
  - Otherwise the counter increments. When count==WAIT_MAX → ERR.
- RD_LATCH: mem_read=1, mdr_read=1, mdr_enable=1, bus_hold=1 → DONE.
- WR_LOAD: mdr_enable=1, mdr_read=0, bus_data_req=1. MDR captures the bus → WR_WAIT.
- WR_WAIT: mem_write=1, mdr_read=0, mdr_enable=0, so MDR drives the mem lines.
  - mem_ready=1 → DONE.
  - Timeout rule is the same as RD_WAIT.
- DONE: done=1. On a load, mdr_read=1 and bus_hold=1 so the loaded word is on the bus for the control unit to capture. → IDLE.
- ERR: done=1, error=1, all memory strobes 0, mdr_read=0 → IDLE.
- Wait counter: cleared on entry to ADDR. Increments once per wait cycle in which mem_ready=0. Saturates at WAIT_MAX.
- Invariants:
  - mem_read and mem_write are never both 1.
  - mem_read=1 implies mdr_read=1 and mdr_enable=0, except in RD_LATCH.
  - mdr_read=0 while mem_read=1 never occurs.
- All outputs are decoded from registered state (Moore), so they are glitch-free.

## Timing
- Reset: clear=0 at an edge → IDLE next cycle. Every output is 0 and the counter and op register are 0. Reset mid-operation aborts immediately: strobes drop in the cycle after the edge and there is no done/error pulse.
- start is accepted only in IDLE; it is ignored while busy, including during the DONE/ERR cycle. Back-to-back: start asserted during the IDLE cycle that follows DONE is accepted.
- Load latency with mem_ready high on the first wait cycle: start sampled at edge 0 → ADDR cycle 1, RD_WAIT 2, RD_LATCH 3, DONE 4. Total 4 cycles plus one cycle per extra wait.
- Store latency with the same conditions: ADDR 1, WR_LOAD 2, WR_WAIT 3, DONE 4.
- Timeout: ERR is entered after WAIT_MAX consecutive not-ready wait cycles. If mem_ready=1 arrives on the same cycle that the count hits WAIT_MAX, ready wins and the access completes normally.
- mem_ready outside the wait states is ignored.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum with explicit 3-bit encoding (IDLE=0 … ERR=7);
  - the op encoding constants OP_LOAD=0 and OP_STORE=1;
  - the default WAIT_MAX.
- One sub-module, wait_timer (CNT_W-bit clear/increment/saturate counter with an expired flag). Everything else is a single FSM module.

## Test plan
- Load, mem_ready high on the first wait cycle: start=1, write_req=0 → mar_enable in cycle 1, mem_read in cycles 2–3, mdr_enable in cycle 3, done in cycle 4 with mdr_read=1 and bus_hold=1.
- Store with 3 wait cycles (mem_ready rises in the 4th WR_WAIT cycle): bus_data_req in cycle 2, mem_write in cycles 3–6, done in cycle 7, error=0, mem_read never 1.
- Timeout, WAIT_MAX=4, mem_ready held low on a load: ERR reached after 4 RD_WAIT cycles; done=1 and error=1 for exactly one cycle; back in IDLE after that.
- Reset mid-operation: clear=0 during the 2nd WR_WAIT cycle → the next cycle shows IDLE, mem_write=0, busy=0, and no done pulse.
- start held high continuously: each access is separated by exactly one IDLE cycle; start during busy is ignored (count done pulses equal to accepted starts).
- Boundary: mem_ready=1 in the same cycle the counter reaches WAIT_MAX → normal completion, error=0.
